// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32I opcodes, instruction field positions and fetch FSM encoding
package rv_pkg;

  localparam logic [6:0]  OP_IMM   = 7'b0010011;
  localparam logic [6:0]  OP_REG   = 7'b0110011;
  localparam logic [6:0]  OP_LUI   = 7'b0110111;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  localparam int OPCODE_LSB = 0;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int FUNCT7_LSB = 25;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_pc_reg.sv
// rtl/if_pc_reg.sv - word-aligned program counter with +4 advance and prioritised load
module if_pc_reg #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write,
  input  logic            pc_load,
  input  logic [PC_W-1:0] pc_target,
  output logic [PC_W-1:0] pc
);

  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);
  localparam logic [PC_W-1:0] PC_RST     = RESET_PC & ALIGN_MASK;

  // Low target bits are dropped by the alignment mask.
  logic unused_target_lo;
  assign unused_target_lo = ^pc_target[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= PC_RST;
    end else if (pc_load) begin
      pc <= pc_target & ALIGN_MASK;
    end else if (pc_write) begin
      pc <= pc + PC_W'(4);
    end
  end

endmodule

// File: rtl/if_unit.sv
// rtl/if_unit.sv - RV32I fetch stage: PC/IR, imem req/ack, field decode (option IF_UNIT_PC_LOAD_EN)
module if_unit
  import rv_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INSN = rv_pkg::NOP_INSN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PC_Write,
  input  logic            IR_Write,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [PC_W-1:0] PC,
  output logic [31:0]     IR,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            ir_valid,
  output logic            busy,
  output logic [31:0]     fetch_cnt
`ifdef IF_UNIT_PC_LOAD_EN
  ,
  input  logic            pc_load,
  input  logic [PC_W-1:0] pc_target
`endif
);

  logic            ld;
  logic [PC_W-1:0] ld_target;

`ifdef IF_UNIT_PC_LOAD_EN
  assign ld        = pc_load;
  assign ld_target = pc_target;
`else
  assign ld        = 1'b0;
  assign ld_target = '0;
`endif

  if_pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst       (rst),
    .pc_write  (PC_Write),
    .pc_load   (ld),
    .pc_target (ld_target),
    .pc        (PC)
  );

  fetch_state_e state, state_nx;
  logic         start_fetch, fetch_done;

  always_comb begin
    state_nx    = state;
    start_fetch = 1'b0;
    fetch_done  = 1'b0;
    case (state)
      IDLE: begin
        if (IR_Write) begin
          start_fetch = 1'b1;
          state_nx    = FETCH;
        end
      end
      FETCH: begin
        if (imem_ack) begin
          fetch_done = 1'b1;
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // The request address is captured once; later PC moves never disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      IR        <= NOP_INSN;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      ir_valid  <= 1'b0;
      busy      <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      busy <= (state_nx == FETCH);
      if (start_fetch) begin
        imem_addr <= PC;
        imem_req  <= 1'b1;
        ir_valid  <= 1'b0;
      end
      if (fetch_done) begin
        IR        <= imem_rdata;
        ir_valid  <= 1'b1;
        imem_req  <= 1'b0;
        fetch_cnt <= fetch_cnt + 32'd1;
      end
    end
  end

  assign opcode = IR[OPCODE_LSB +: 7];
  assign rd     = IR[RD_LSB     +: 5];
  assign funct3 = IR[FUNCT3_LSB +: 3];
  assign rs1    = IR[RS1_LSB    +: 5];
  assign rs2    = IR[RS2_LSB    +: 5];
  assign funct7 = IR[FUNCT7_LSB +: 7];

endmodule

// File: tb/tb_if_unit.sv
// tb/tb_if_unit.sv - self-checking bench for if_unit against a transaction-level fetch model
module tb_if_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        PC_Write, IR_Write, imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req, ir_valid, busy;
  logic [31:0] imem_addr, PC, IR, fetch_cnt;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
`ifdef IF_UNIT_PC_LOAD_EN
  logic        pc_load;
  logic [31:0] pc_target;
`endif

  logic        w_pc_write;
  logic        w_req, w_valid, w_busy;
  logic [31:0] w_addr, w_pc, w_ir, w_cnt;
  logic [6:0]  w_opcode, w_funct7;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rs1, w_rs2, w_rd;

  logic [31:0] m_pc, m_ir, m_addr, m_cnt;
  logic        m_req, m_valid, m_busy;
  int          n_checks = 0;
  int          n_fail   = 0;

  if_unit dut (
    .clk(clk), .rst(rst), .PC_Write(PC_Write), .IR_Write(IR_Write),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .PC(PC), .IR(IR), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1(rs1), .rs2(rs2), .rd(rd), .ir_valid(ir_valid), .busy(busy), .fetch_cnt(fetch_cnt)
`ifdef IF_UNIT_PC_LOAD_EN
    , .pc_load(pc_load), .pc_target(pc_target)
`endif
  );

  // Second instance starts near the top of the address space for the wrap check.
  if_unit #(.RESET_PC(32'hFFFF_FFFB)) dut_w (
    .clk(clk), .rst(rst), .PC_Write(w_pc_write), .IR_Write(1'b0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(1'b0), .imem_rdata(32'h0),
    .PC(w_pc), .IR(w_ir), .opcode(w_opcode), .funct3(w_funct3), .funct7(w_funct7),
    .rs1(w_rs1), .rs2(w_rs2), .rd(w_rd), .ir_valid(w_valid), .busy(w_busy), .fetch_cnt(w_cnt)
`ifdef IF_UNIT_PC_LOAD_EN
    , .pc_load(1'b0), .pc_target(32'h0)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 32'h0; m_ir = 32'h0000_0013; m_addr = 32'h0; m_cnt = 32'h0;
    m_req = 1'b0; m_valid = 1'b0; m_busy = 1'b0;
  endtask

  task automatic step();
    if (m_busy) begin
      if (imem_ack) begin
        m_ir = imem_rdata; m_valid = 1'b1; m_req = 1'b0; m_busy = 1'b0; m_cnt = m_cnt + 1;
      end
    end else if (IR_Write) begin
      m_addr = m_pc; m_req = 1'b1; m_valid = 1'b0; m_busy = 1'b1;
    end
`ifdef IF_UNIT_PC_LOAD_EN
    if (pc_load) m_pc = pc_target & ~32'h3;
    else
`endif
    if (PC_Write) m_pc = m_pc + 32'd4;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    PC_Write = 0; IR_Write = 0; imem_ack = 0; imem_rdata = 32'h0; w_pc_write = 0;
`ifdef IF_UNIT_PC_LOAD_EN
    pc_load = 0; pc_target = 32'h0;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    model_reset();
    #2;
    n_checks++;
    if ({imem_req, ir_valid, busy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b exp 000", {imem_req, ir_valid, busy});
    end
    n_checks++;
    if (PC !== 32'h0 || IR !== 32'h0000_0013 || imem_addr !== 32'h0 || fetch_cnt !== 32'h0) begin
      n_fail++; $display("FAIL reset_regs: pc %h ir %h addr %h cnt %h", PC, IR, imem_addr, fetch_cnt);
    end
    n_checks++;
    if (w_pc !== 32'hFFFF_FFF8) begin
      n_fail++; $display("FAIL reset_pc_align: got %h exp fffffff8", w_pc);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_fetch();
    IR_Write = 1; step(); IR_Write = 0;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || busy !== 1'b1 || ir_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_req: req %b addr %h busy %b valid %b", imem_req, imem_addr, busy, ir_valid);
    end
    step();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL basic_hold: req %b addr %h exp 1 0", imem_req, imem_addr);
    end
    imem_ack = 1; imem_rdata = 32'h0020_8133; step(); imem_ack = 0;
    n_checks++;
    if (ir_valid !== 1'b1 || IR !== 32'h0020_8133 || imem_req !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_done: valid %b ir %h req %b busy %b", ir_valid, IR, imem_req, busy);
    end
    n_checks++;
    if ({opcode, rd, rs1, rs2, funct3, funct7} !== {7'b0110011, 5'd2, 5'd1, 5'd2, 3'd0, 7'd0}) begin
      n_fail++; $display("FAIL basic_fields: op %b rd %0d rs1 %0d rs2 %0d f3 %0d f7 %0d", opcode, rd, rs1, rs2, funct3, funct7);
    end
    n_checks++;
    if (fetch_cnt !== 32'd1) begin
      n_fail++; $display("FAIL basic_cnt: got %0d exp 1", fetch_cnt);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] word;
    word = $urandom;
    PC_Write = 1;
    repeat (4) step();
    IR_Write = 1; step(); IR_Write = 0; PC_Write = 0;
    n_checks++;
    if (imem_addr !== 32'h10 || PC !== 32'h14 || imem_req !== 1'b1) begin
      n_fail++; $display("FAIL same_cycle: addr %h pc %h req %b exp 10 14 1", imem_addr, PC, imem_req);
    end
    imem_ack = 1; imem_rdata = word; step(); imem_ack = 0;
    n_checks++;
    if (IR !== word || fetch_cnt !== 32'd2) begin
      n_fail++; $display("FAIL same_cycle_ir: ir %h cnt %0d exp %h 2", IR, fetch_cnt, word);
    end
  endtask

  task automatic test_pc_write_during_fetch();
    logic [31:0] a0, p0, c0;
    a0 = m_pc; c0 = m_cnt;
    IR_Write = 1; step(); IR_Write = 0;
    p0 = m_pc;
    for (int i = 0; i < 5; i++) begin
      PC_Write = (i == 1);
      IR_Write = (i == 3);
      step();
      n_checks++;
      if (imem_addr !== a0 || imem_req !== 1'b1 || busy !== 1'b1) begin
        n_fail++; $display("FAIL busy_hold[%0d]: addr %h req %b busy %b exp %h 1 1", i, imem_addr, imem_req, busy, a0);
      end
    end
    PC_Write = 0; IR_Write = 0;
    imem_ack = 1; imem_rdata = 32'h0000_00B7; step(); imem_ack = 0;
    step();
    n_checks++;
    if (PC !== p0 + 32'd4 || fetch_cnt !== c0 + 32'd1 || busy !== 1'b0 || opcode !== 7'b0110111) begin
      n_fail++; $display("FAIL busy_result: pc %h cnt %0d busy %b op %b", PC, fetch_cnt, busy, opcode);
    end
  endtask

  task automatic test_wrap();
    w_pc_write = 1; step();
    n_checks++;
    if (w_pc !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_pre: got %h exp fffffffc", w_pc);
    end
    step(); w_pc_write = 0;
    n_checks++;
    if (w_pc !== 32'h0) begin
      n_fail++; $display("FAIL wrap: got %h exp 00000000", w_pc);
    end
  endtask

`ifdef IF_UNIT_PC_LOAD_EN
  task automatic test_pc_load();
    pc_load = 1; pc_target = 32'h0000_0123; PC_Write = 1; step();
    pc_load = 0; PC_Write = 0;
    n_checks++;
    if (PC !== 32'h0000_0120) begin
      n_fail++; $display("FAIL pc_load: got %h exp 00000120", PC);
    end
  endtask
`endif

  task automatic test_reset_mid_fetch();
    IR_Write = 1; step(); IR_Write = 0;
    step();
    rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (imem_req !== 1'b0 || IR !== 32'h0000_0013 || ir_valid !== 1'b0 || busy !== 1'b0 || fetch_cnt !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid: req %b ir %h valid %b busy %b cnt %0d", imem_req, IR, ir_valid, busy, fetch_cnt);
    end
    #2;
    rst = 1'b0;
    imem_ack = 1; imem_rdata = 32'hDEAD_BEEF; step(); step(); imem_ack = 0;
    n_checks++;
    if (ir_valid !== 1'b0 || IR !== 32'h0000_0013 || fetch_cnt !== 32'h0 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL rst_stale_ack: valid %b ir %h cnt %0d req %b", ir_valid, IR, fetch_cnt, imem_req);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      IR_Write   = ($urandom % 3) == 0;
      PC_Write   = ($urandom % 3) == 0;
      imem_ack   = ($urandom % 2) == 0;
      imem_rdata = $urandom;
`ifdef IF_UNIT_PC_LOAD_EN
      pc_load   = ($urandom % 8) == 0;
      pc_target = $urandom;
`endif
      step();
      n_checks++;
      if (PC !== m_pc || imem_addr !== m_addr || fetch_cnt !== m_cnt) begin
        n_fail++; $display("FAIL rand_regs[%0d]: pc %h/%h addr %h/%h cnt %0d/%0d", i, PC, m_pc, imem_addr, m_addr, fetch_cnt, m_cnt);
      end
      n_checks++;
      if ({imem_req, ir_valid, busy} !== {m_req, m_valid, m_busy} || IR !== m_ir) begin
        n_fail++; $display("FAIL rand_state[%0d]: req/valid/busy %b exp %b ir %h exp %h", i, {imem_req, ir_valid, busy}, {m_req, m_valid, m_busy}, IR, m_ir);
      end
      n_checks++;
      if ({funct7, rs2, rs1, funct3, rd, opcode} !== m_ir) begin
        n_fail++; $display("FAIL rand_fields[%0d]: got %h exp %h", i, {funct7, rs2, rs1, funct3, rd, opcode}, m_ir);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_same_cycle();
    test_pc_write_during_fetch();
    test_wrap();
`ifdef IF_UNIT_PC_LOAD_EN
    test_pc_load();
`endif
    test_reset_mid_fetch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_unit.md
Name: if_unit

Overview:
- Instruction-fetch stage of the multi-cycle RV32I core; sits directly upstream of the control unit.
- Owns the PC and IR registers. Reacts to the control unit's PC_Write / IR_Write strobes.
- Runs a req/ack handshake to instruction memory and presents decoded instruction fields (opcode, funct3, funct7, register indices) to the control unit and register file.

Parameters:
- PC_W, 32, width of PC and memory address.
- RESET_PC, 32'h0000_0000, PC value after reset; bits [1:0] ignored, forced to 0.
- NOP_INSN, 32'h0000_0013, IR value after reset (addi x0,x0,0).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- PC_Write  in  1  from control unit; PC <= PC+4 on this cycle.
- IR_Write  in  1  from control unit; start a fetch at current PC.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  PC_W  byte address of the outstanding fetch.
- imem_ack  in  1  memory returns data this cycle.
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- PC  out  PC_W  current program counter.
- IR  out  32  latched instruction.
- opcode  out  7  IR[6:0].
- funct3  out  3  IR[14:12].
- funct7  out  7  IR[31:25].
- rs1  out  5  IR[19:15].
- rs2  out  5  IR[24:20].
- rd  out  5  IR[11:7].
- ir_valid  out  1  IR holds a completed fetch.
- busy  out  1  fetch outstanding; control unit stalls.
- fetch_cnt  out  32  count of completed fetches.

Behaviour:
- Reset values (asserted asynchronously, all registers):
  - PC = RESET_PC & ~3; IR = NOP_INSN; imem_req = 0; imem_addr = 0.
  - ir_valid = 0; busy = 0; fetch_cnt = 0; FSM = IDLE.
- FSM has two states, IDLE and FETCH.
  - IDLE, IR_Write=1: imem_addr <= PC, imem_req <= 1, ir_valid <= 0, FSM -> FETCH.
    - Request becomes visible the cycle after the strobe.
  - FETCH: imem_req and imem_addr are held stable until imem_ack.
  - FETCH, imem_ack=1: IR <= imem_rdata, ir_valid <= 1, imem_req <= 0, fetch_cnt <= fetch_cnt+1, FSM -> IDLE.
  - imem_ack while in IDLE is ignored.
- Latency: minimum 2 cycles from IR_Write to ir_valid (ack in the first FETCH cycle). No upper bound; waits indefinitely for ack.
- busy = (FSM == FETCH), registered.
- IR_Write while in FETCH: ignored; no queueing.
- PC_Write:
  - PC <= PC+4 in any state, modulo 2^PC_W (0xFFFF_FFFC -> 0x0000_0000).
  - Never alters an outstanding imem_addr.
- IR_Write and PC_Write in the same IDLE cycle: fetch uses the old PC; PC advances in the same edge.
- Field outputs are combinational slices of IR. They are stable whenever ir_valid=1 and change only on the ack edge.
- PC[1:0] is always 00.
- fetch_cnt wraps 0xFFFF_FFFF -> 0.
- Reset mid-fetch: imem_req drops immediately (asynchronously), the in-flight ack is discarded, and IR returns to NOP_INSN.

Optional Feature:
- Macro: IF_UNIT_PC_LOAD_EN.
- Defined:
  - Adds ports pc_load (in, 1) and pc_target (in, PC_W).
  - pc_load=1: PC <= pc_target & ~3 on that edge; pc_load has priority over PC_Write.
  - Does not affect an outstanding fetch.
- Undefined: ports are absent; PC changes only via PC_Write and reset.

Decomposition:
- Shared package rv_pkg:
  - opcode constants OP_IMM=7'b0010011, OP_REG=7'b0110011, OP_LUI=7'b0110111;
  - NOP_INSN;
  - instruction field bit-position constants;
  - fetch FSM state encoding (IDLE=1'b0, FETCH=1'b1).
- One natural sub-module, if_pc_reg: PC register with reset, +4 increment and optional load. FSM, IR and counter stay in if_unit.

Test Plan:
- Reset release, IR_Write pulse at cycle 2, ack at cycle 4 with rdata=32'h0020_8133 -> imem_addr=0 held during cycles 3-4; ir_valid=1 at cycle 5; opcode=7'b0110011, rd=2, rs1=1, rs2=2; fetch_cnt=1.
- IR_Write and PC_Write together from PC=0x10 -> imem_addr=0x10, PC=0x14 next cycle; IR latched from 0x10 on ack.
- PC_Write during FETCH with ack delayed 5 cycles -> imem_addr stays constant; PC increments once; second IR_Write while busy is ignored (fetch_cnt +1 only).
- PC=0xFFFF_FFFC plus PC_Write -> PC=0x0000_0000.
- rst asserted mid-FETCH -> imem_req=0 immediately, IR=0x0000_0013, ir_valid=0; ack arriving after reset has no effect.
- (IF_UNIT_PC_LOAD_EN) pc_load with pc_target=0x0000_0123 and PC_Write in the same cycle -> PC=0x0000_0120.
